// File: rtl/kernel_pkg.sv
// Shared widths, mode encodings and the bias/shift/ReLU/saturate helper for the kernel datapath.
package kernel_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC   = 8;
  localparam int DEF_ACC_W  = 40;

  localparam logic [1:0] MODE_CONV0 = 2'b00;
  localparam logic [1:0] MODE_MAX   = 2'b01;
  localparam logic [1:0] MODE_CONV  = 2'b10;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] value;
    logic                  clipped;
  } sat_t;

  // One extra bit of headroom so adding the aligned bias to a full-range acc cannot wrap.
  function automatic sat_t sat_round(input logic signed [DEF_ACC_W-1:0]  acc,
                                     input logic signed [DEF_DATA_W-1:0] bias,
                                     input logic                         relu);
    logic signed [DEF_ACC_W:0] bias_ext;
    logic signed [DEF_ACC_W:0] sum;
    logic signed [DEF_ACC_W:0] s;
    logic signed [DEF_ACC_W:0] hi;
    logic signed [DEF_ACC_W:0] lo;
    sat_t r;
    bias_ext = {{(DEF_ACC_W+1-DEF_DATA_W){bias[DEF_DATA_W-1]}}, bias};
    sum      = {acc[DEF_ACC_W-1], acc} + (bias_ext <<< DEF_FRAC);
    s        = sum >>> DEF_FRAC;
    hi       = {{(DEF_ACC_W+2-DEF_DATA_W){1'b0}}, {(DEF_DATA_W-1){1'b1}}};
    lo       = {{(DEF_ACC_W+2-DEF_DATA_W){1'b1}}, {(DEF_DATA_W-1){1'b0}}};
    if (relu && s[DEF_ACC_W]) s = '0;
    if (s > hi) begin
      r.value   = hi[DEF_DATA_W-1:0];
      r.clipped = 1'b1;
    end else if (s < lo) begin
      r.value   = lo[DEF_DATA_W-1:0];
      r.clipped = 1'b1;
    end else begin
      r.value   = s[DEF_DATA_W-1:0];
      r.clipped = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/kernel_datapath_ctrl_delay.sv
// Fixed-depth register delay line that realigns the CU control word with memory read data.
module ctrl_delay #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [DEPTH-1:0][W-1:0] stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/kernel_datapath.sv
// MAC / max-pool kernel with bias, ReLU and saturation, driving the result-memory write port.
module kernel_datapath
  import kernel_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int FRAC    = DEF_FRAC,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              init,
  input  logic [1:0]        mode,
  input  logic              bias_en,
  input  logic              relu_en,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] result_idx,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] weight_in,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              sat_flag
);

  localparam int CW = ADDR_W + 7;
  localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  logic [CW-1:0]     ctrl_in;
  logic [CW-1:0]     ctrl_a;
  logic              en_a, init_a, bias_en_a, relu_a, we_a;
  logic [1:0]        mode_a;
  logic [ADDR_W-1:0] idx_a;

  assign ctrl_in = {en, init, mode, bias_en, relu_en, write_enable, result_idx};

  ctrl_delay #(.W(CW), .DEPTH(MEM_LAT)) u_ctrl_delay (
    .clk (clk),
    .rst (rst),
    .d   (ctrl_in),
    .q   (ctrl_a)
  );

  assign {en_a, init_a, mode_a, bias_en_a, relu_a, we_a, idx_a} = ctrl_a;

  logic signed [DATA_W-1:0]   d_s, w_s;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_reg;
  logic signed [DATA_W-1:0]   max_reg;
  logic signed [DATA_W-1:0]   bias_reg;
  logic                       is_mac;

  assign d_s      = data_in;
  assign w_s      = weight_in;
  assign prod     = d_s * w_s;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign is_mac   = (mode_a == MODE_CONV0) || (mode_a == MODE_CONV);

  // A bias fetch cycle owns the memory port, so it pre-empts any MAC/max update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg  <= '0;
      max_reg  <= MIN_VAL;
      bias_reg <= '0;
    end else if (bias_en_a) begin
      bias_reg <= w_s;
    end else if (init_a && !en_a) begin
      acc_reg <= '0;
      max_reg <= MIN_VAL;
    end else if (init_a) begin
      acc_reg <= prod_ext;
      max_reg <= d_s;
    end else if (en_a && is_mac) begin
      acc_reg <= acc_reg + prod_ext;
    end else if (en_a && (mode_a == MODE_MAX) && (d_s > max_reg)) begin
      max_reg <= d_s;
    end
  end

  sat_t                sr;
  logic [DATA_W-1:0]   wr_val;
  logic                wr_clip;

  assign sr = sat_round(acc_reg, bias_reg, relu_a);

  always_comb begin
    wr_val  = '0;
    wr_clip = 1'b0;
    if (is_mac) begin
      wr_val  = sr.value;
      wr_clip = sr.clipped;
    end else if (mode_a == MODE_MAX) begin
      wr_val = max_reg;
    end
  end

  // Reads pre-edge register values, so a write coinciding with the next window's init is unaffected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      sat_flag  <= 1'b0;
    end else begin
      mem_wen <= we_a;
      if (we_a) begin
        mem_addr  <= idx_a;
        mem_wdata <= wr_val;
        if (wr_clip) sat_flag <= 1'b1;
      end
    end
  end

endmodule
